// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues word fetches over a
// req/ack handshake, holds the fetched word for decode, handles redirects
// (flushing wrong-path fetches) and raises a sticky fault on ack timeout.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        dec_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [31:0]      NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt;
    logic [31:0]      r_addr, w_addr_nxt;
    logic             r_req, w_req_nxt;
    logic             r_valid, w_valid_nxt;
    logic [31:0]      r_inst, w_inst_nxt;
    logic [31:0]      r_ipc, w_ipc_nxt;
    logic             r_fault, w_fault_nxt;
    logic             r_drop, w_drop_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic [31:0]      w_redir_pc;
    logic             w_handshake;

    assign w_redir_pc  = redirect_pc & ~32'h0000_0003;
    assign w_handshake = r_valid & dec_ready & ~stall;

    // Next-state and next-output computation for the fetch sequencer.
    // imem_addr is a separate register from the PC so that a redirect can
    // move the PC while an un-acked request keeps presenting its old address.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_req_nxt   = r_req;
        w_valid_nxt = r_valid;
        w_inst_nxt  = r_inst;
        w_ipc_nxt   = r_ipc;
        w_fault_nxt = r_fault;
        w_drop_nxt  = r_drop;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
                if (redirect) begin
                    w_pc_nxt = w_redir_pc;
                end else begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = r_pc;
                end
            end

            ST_FETCH: begin
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    if (r_req && imem_ack) begin
                        // Data of this ack is wrong-path: discard and re-request.
                        w_req_nxt  = 1'b0;
                        w_drop_nxt = 1'b0;
                    end else if (r_req) begin
                        // Request cannot be aborted; discard its data when it lands.
                        w_drop_nxt = 1'b1;
                    end
                end else if (!r_req) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = r_pc;
                    w_cnt_nxt  = '0;
                end else if (imem_ack) begin
                    w_req_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    if (r_drop) begin
                        w_drop_nxt = 1'b0;
                    end else begin
                        w_inst_nxt  = imem_rdata;
                        w_ipc_nxt   = r_addr;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_fault_nxt = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_FETCH;
                end else if (w_handshake) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FAULT: begin
                w_req_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_inst  <= NOP;
            r_ipc   <= '0;
            r_fault <= 1'b0;
            r_drop  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_req   <= w_req_nxt;
            r_valid <= w_valid_nxt;
            r_inst  <= w_inst_nxt;
            r_ipc   <= w_ipc_nxt;
            r_fault <= w_fault_nxt;
            r_drop  <= w_drop_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign inst_valid  = r_valid;
    assign inst_out    = r_inst;
    assign inst_pc     = r_ipc;
    assign fetch_fault = r_fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        dec_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(
        .RESET_PC   (RST_PC),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .dec_ready  (dec_ready),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        dec_ready   = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req === 1'b1) begin
                found = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit f;
        reset = 1'b1;
        idle_inputs();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        total++; if (inst_out !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst got=%h exp=00000013", inst_out); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_ipc got=%h exp=00000000", inst_pc); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
        reset = 1'b0;
        wait_req(f);
        total++; if (!f || imem_addr !== RST_PC) begin bad++; $display("FAIL reset_first_req found=%0d addr=%h exp=%h", f, imem_addr, RST_PC); end
        // Reset in the middle of a request must drop it without a clock edge.
        reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_async_req got=%b exp=0", imem_req); end
        tick();
    endtask

    task automatic test_throughput();
        int          vcyc[$];
        logic [31:0] vpc[$];
        logic [31:0] vins[$];
        do_reset();
        dec_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (inst_valid) begin
                vcyc.push_back(c);
                vpc.push_back(inst_pc);
                vins.push_back(inst_out);
            end
            if (imem_req) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
        end
        idle_inputs();
        total++; if (vcyc.size() < 4) begin bad++; $display("FAIL tput_count got=%0d exp>=4", vcyc.size()); end
        for (int k = 0; k < vcyc.size(); k++) begin
            total++;
            if (vpc[k] !== 32'(k * 4) || vins[k] !== mem_word(32'(k * 4))) begin
                bad++; $display("FAIL tput_inst[%0d] pc=%h inst=%h exp pc=%h inst=%h", k, vpc[k], vins[k], 32'(k * 4), mem_word(32'(k * 4)));
            end
            if (k > 0) begin
                total++;
                if (vcyc[k] - vcyc[k-1] != 3) begin bad++; $display("FAIL tput_period[%0d] got=%0d exp=3", k, vcyc[k] - vcyc[k-1]); end
            end
        end
    endtask

    task automatic test_wait_ack();
        bit f;
        do_reset();
        dec_ready = 1'b1;
        wait_req(f);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        imem_ack = 1'b0;
        wait_req(f);
        total++; if (!f) begin bad++; $display("FAIL wait_req_seen got=0 exp=1"); end
        for (int w = 0; w < 4; w++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL wait_hold[%0d] req=%b addr=%h exp req=1 addr=00000004", w, imem_req, imem_addr); end
            total++;
            if (inst_valid !== 1'b0) begin bad++; $display("FAIL wait_valid_early[%0d] got=%b exp=0", w, inst_valid); end
            if (w == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(32'h4);
            end
            tick();
        end
        imem_ack = 1'b0;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_out !== mem_word(32'h4)) begin
            bad++; $display("FAIL wait_result valid=%b pc=%h inst=%h exp 1/00000004/%h", inst_valid, inst_pc, inst_out, mem_word(32'h4));
        end
    endtask

    task automatic test_backpressure();
        bit f;
        do_reset();
        wait_req(f);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        imem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            stall     = 1'b1;
            dec_ready = 1'($urandom_range(0, 1));
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== mem_word(32'h0) || imem_req !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] valid=%b pc=%h inst=%h req=%b", c, inst_valid, inst_pc, inst_out, imem_req);
            end
            tick();
        end
        stall     = 1'b0;
        dec_ready = 1'b1;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL bp_before_hs valid=%b pc=%h exp 1/00000000", inst_valid, inst_pc); end
        tick();
        dec_ready = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL bp_after_hs got=%b exp=0", inst_valid); end
        wait_req(f);
        total++; if (!f || imem_addr !== 32'h4) begin bad++; $display("FAIL bp_next_addr found=%0d addr=%h exp=00000004", f, imem_addr); end
    endtask

    task automatic test_redirect_pending();
        bit f;
        bit seen;
        do_reset();
        dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req(f);
            if (!f || imem_addr == 32'h8) break;
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            tick();
            imem_ack = 1'b0;
        end
        total++; if (!f || imem_addr !== 32'h8) begin bad++; $display("FAIL rp_reach8 found=%0d addr=%h exp=00000008", f, imem_addr); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        for (int w = 0; w < 2; w++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL rp_no_abort[%0d] req=%b addr=%h exp 1/00000008", w, imem_req, imem_addr); end
            if (w == 1) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(32'h8);
            end
            tick();
        end
        imem_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) seen = 1'b1;
            if (imem_req) break;
            tick();
        end
        total++; if (seen) begin bad++; $display("FAIL rp_wrong_path_presented got=1 exp=0"); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL rp_refetch req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h100);
        tick();
        imem_ack = 1'b0;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_out !== mem_word(32'h100)) begin
            bad++; $display("FAIL rp_result valid=%b pc=%h inst=%h exp 1/00000100/%h", inst_valid, inst_pc, inst_out, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_flush();
        bit f;
        do_reset();
        dec_ready = 1'b1;
        // Redirect coinciding with the ack.
        wait_req(f);
        imem_ack    = 1'b1;
        imem_rdata  = mem_word(imem_addr);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rf_ack valid=%b req=%b exp 0/0", inst_valid, imem_req); end
        wait_req(f);
        total++; if (!f || imem_addr !== 32'h200) begin bad++; $display("FAIL rf_ack_target found=%0d addr=%h exp=00000200", f, imem_addr); end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h200);
        tick();
        imem_ack = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin bad++; $display("FAIL rf_ack_result valid=%b pc=%h exp 1/00000200", inst_valid, inst_pc); end
        // Redirect in HOLD together with a would-be handshake.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_030E;
        tick();
        redirect = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rf_hold_valid got=%b exp=0", inst_valid); end
        wait_req(f);
        total++; if (!f || imem_addr !== 32'h30C) begin bad++; $display("FAIL rf_hold_target found=%0d addr=%h exp=0000030c", f, imem_addr); end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h30C);
        tick();
        imem_ack = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h30C || inst_out !== mem_word(32'h30C)) begin bad++; $display("FAIL rf_hold_result valid=%b pc=%h inst=%h", inst_valid, inst_pc, inst_out); end
    endtask

    task automatic test_timeout();
        bit f;
        int n;
        do_reset();
        dec_ready = 1'b1;
        wait_req(f);
        // Ack in the last allowed cycle is still accepted.
        for (int w = 0; w < 16; w++) begin
            total++;
            if (imem_req !== 1'b1 || fetch_fault !== 1'b0) begin bad++; $display("FAIL to_late_ack_wait[%0d] req=%b fault=%b exp 1/0", w, imem_req, fetch_fault); end
            if (w == 15) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end
            tick();
        end
        imem_ack = 1'b0;
        total++; if (inst_valid !== 1'b1 || fetch_fault !== 1'b0) begin bad++; $display("FAIL to_late_ack_ok valid=%b fault=%b exp 1/0", inst_valid, fetch_fault); end
        wait_req(f);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!imem_req) break;
            n++;
            tick();
        end
        total++; if (n != 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", n); end
        total++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL to_fault fault=%b req=%b exp 1/0", fetch_fault, imem_req); end
        for (int c = 0; c < 20; c++) begin
            imem_ack    = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            redirect    = 1'($urandom_range(0, 1));
            redirect_pc = $urandom;
            tick();
            total++;
            if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
                bad++; $display("FAIL to_absorb[%0d] fault=%b req=%b valid=%b exp 1/0/0", c, fetch_fault, imem_req, inst_valid);
            end
        end
        idle_inputs();
        reset = 1'b1;
        #1;
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL to_reset_clear got=%b exp=0", fetch_fault); end
        tick();
        reset = 1'b0;
        wait_req(f);
        total++; if (!f || imem_addr !== RST_PC) begin bad++; $display("FAIL to_restart found=%0d addr=%h exp=%h", f, imem_addr, RST_PC); end
    endtask

    // Randomized run: the model tracks only the architectural fetch stream
    // (next expected fetch address, whether the outstanding request is
    // wrong-path, and the instruction owed to decode).
    task automatic test_random();
        logic [31:0] q_pc[$];
        logic [31:0] q_ins[$];
        bit          out_busy;
        bit          out_wrong;
        logic [31:0] out_addr;
        int          out_wait;
        int          out_lat;
        logic [31:0] m_pc;
        bit          prev_redirect;
        int          consumed;
        out_busy = 0; out_wrong = 0; out_addr = '0; out_wait = 0; out_lat = 0;
        m_pc = RST_PC; prev_redirect = 0; consumed = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (imem_req) begin
                total++;
                if (!out_busy) begin
                    if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, imem_addr, m_pc); end
                    out_busy = 1; out_wrong = 0; out_addr = imem_addr; out_wait = 0;
                    out_lat = $urandom_range(0, 6);
                end else if (imem_addr !== out_addr) begin
                    bad++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", c, imem_addr, out_addr);
                end
            end
            if (prev_redirect) begin
                total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rnd_valid_after_redirect cyc=%0d got=%b exp=0", c, inst_valid); end
            end
            total++;
            if (inst_valid) begin
                if (q_pc.size() == 0) begin bad++; $display("FAIL rnd_spurious_valid cyc=%0d pc=%h", c, inst_pc); end
                else if (inst_pc !== q_pc[0] || inst_out !== q_ins[0]) begin
                    bad++; $display("FAIL rnd_inst cyc=%0d pc=%h inst=%h exp %h/%h", c, inst_pc, inst_out, q_pc[0], q_ins[0]);
                end
            end else if (q_pc.size() != 0) begin
                bad++; $display("FAIL rnd_missing_valid cyc=%0d exp pc=%h", c, q_pc[0]);
            end
            total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rnd_fault cyc=%0d got=1 exp=0", c); end

            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom & 32'h0000_0FFF;
            dec_ready   = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            if (imem_req) begin
                imem_ack   = (out_wait >= out_lat);
                imem_rdata = imem_ack ? mem_word(out_addr) : $urandom;
            end else begin
                imem_ack   = ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end

            if (imem_req && imem_ack) begin
                if (!redirect && !out_wrong) begin
                    q_pc.push_back(out_addr);
                    q_ins.push_back(mem_word(out_addr));
                    m_pc = out_addr + 32'd4;
                end
                out_busy = 0;
            end else if (imem_req) begin
                out_wait++;
            end
            if (inst_valid && dec_ready && !stall && !redirect && q_pc.size() != 0) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
                consumed++;
            end
            if (redirect) begin
                q_pc.delete();
                q_ins.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (imem_req && !imem_ack) out_wrong = 1;
            end
            prev_redirect = redirect;
        end
        idle_inputs();
        total++; if (consumed < 50) begin bad++; $display("FAIL rnd_progress got=%0d exp>=50", consumed); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_throughput();
        test_wait_ack();
        test_backpressure();
        test_redirect_pending();
        test_redirect_flush();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
